rand_matrix_filler: RTL and testbench
=====================================

Name: rand_matrix_filler

Overview:
- Consumer/driver side of the LFSR random-number core: requests mapped random values and writes a rows x cols matrix of signed 8-bit elements into matrix storage.
- Programs the RNG range, primes the RNG's 3-stage pipeline, then streams elements in row-major order over a valid/ready write port.
- Checks every delivered value against the programmed range.
- Sits between the menu/control FSM (start/abort) and the matrix storage write port.

Parameters:
- MAX_DIM, 5, maximum rows/cols accepted.
- DIM_W, 3, width of row/col fields.
- DATA_W, 8, element width; signed two's complement.
- PRIME_CYCLES, 3, rng_en cycles issued before the first value is treated as valid; equals RNG pipeline depth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE.
- cfg_rows  in  DIM_W  requested rows, valid 1..MAX_DIM.
- cfg_cols  in  DIM_W  requested cols, valid 1..MAX_DIM.
- cfg_min  in  DATA_W  signed lower bound.
- cfg_max  in  DATA_W  signed upper bound.
- rng_en  out  1  advance enable to RNG core.
- rng_min  out  DATA_W  latched lower bound to RNG core.
- rng_max  out  DATA_W  latched upper bound to RNG core.
- rng_val  in  DATA_W  mapped random value from RNG core.
- wr_valid  out  1  element write valid.
- wr_ready  in  1  storage accepts element.
- wr_row  out  DIM_W  row index, 0-based.
- wr_col  out  DIM_W  col index, 0-based.
- wr_data  out  DATA_W  element value; equals rng_val.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last element is accepted.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- range_err  out  1  sticky; a delivered value was outside [min,max]. Cleared on an accepted start.

Behaviour:
- Reset: state IDLE. rng_en=0, wr_valid=0, busy=0, done=0, cfg_err=0, range_err=0. wr_row=0, wr_col=0, rng_min=0, rng_max=0.
- Start acceptance (IDLE, start=1):
  - Reject if rows or cols is outside 1..MAX_DIM, or signed cfg_min > cfg_max. On reject: pulse cfg_err next cycle, stay IDLE, leave all latches unchanged.
  - On accept: latch rows, cols, min and max. Drive rng_min/rng_max from the latched values. Clear range_err. Go to SETTLE.
- SETTLE: 1 cycle, rng_en=0. Lets the RNG range register load the new bounds. Go to PRIME.
- PRIME: rng_en=1 for exactly PRIME_CYCLES cycles (internal counter), wr_valid=0. Go to FILL.
- FILL:
  - wr_valid=1; wr_data=rng_val (combinational); wr_row/wr_col come from registered counters.
  - rng_en = wr_ready. When stalled, the RNG pipeline freezes, so wr_data stays stable while wr_valid && !wr_ready.
  - On handshake (wr_valid && wr_ready): compare wr_data as signed against latched min/max; if outside, set range_err.
  - Advance: col+1. If col == cols-1, col wraps to 0 and row increments.
  - If row == rows-1 && col == cols-1: go to DONE instead of advancing.
- DONE: 1 cycle. done=1, wr_valid=0, rng_en=0. Go to IDLE; row/col return to 0.
- Element count is always rows*cols (1..25). Exactly that many handshakes occur, with no duplicate or skipped index.
- abort: in any non-IDLE state, next state is IDLE. Outputs deassert next cycle; no done pulse; counters clear. A handshake in the abort cycle still counts as a write to storage, but the fill is not completed. abort has priority over every transition.
- start while busy: ignored.
- start and abort together in IDLE: abort wins; remain IDLE.
- rst_n asserted mid-fill: immediate return to reset values. Storage contents are not this block's responsibility.

Test Plan:
- rows=2, cols=3, min=-5, max=10, wr_ready tied 1 -> SETTLE 1 cycle and PRIME 3 cycles precede the first wr_valid. Six consecutive handshakes at (0,0)(0,1)(0,2)(1,0)(1,1)(1,2). done pulses 1 cycle after (1,2). All data in [-5,10]; range_err=0.
- rows=1, cols=1, min=max=7 -> single write of 7 at (0,0), then done. rng_en high for exactly 4 cycles total.
- rows=3, cols=3, wr_ready toggling 1,0,0,1,... -> wr_data and indices stable during every stall, rng_en=0 while wr_ready=0, exactly 9 handshakes.
- start with rows=0, cols=6, or min=20/max=-3 -> cfg_err pulses once, busy stays 0, no rng_en activity.
- abort asserted during the 4th element of a 5x5 fill -> busy=0 next cycle, no done pulse. A following valid start restarts at (0,0).
- Stub RNG returning 100 with max=50 -> range_err sets on the first handshake, stays set through done, and clears on the next accepted start.

Source files
------------

// File: rtl/rand_matrix_filler.sv
// Drives the LFSR random-number core and streams a rows x cols matrix of signed
// elements, row-major, into matrix storage over a valid/ready write port.
module rand_matrix_filler #(
  parameter int MAX_DIM      = 5,
  parameter int DIM_W        = 3,
  parameter int DATA_W       = 8,
  parameter int PRIME_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [DATA_W-1:0] cfg_min,
  input  logic [DATA_W-1:0] cfg_max,
  output logic              rng_en,
  output logic [DATA_W-1:0] rng_min,
  output logic [DATA_W-1:0] rng_max,
  input  logic [DATA_W-1:0] rng_val,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DIM_W-1:0]  wr_row,
  output logic [DIM_W-1:0]  wr_col,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              range_err
);

  localparam int PCW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_PRIME  = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic [PCW-1:0]    prime_cnt_q, prime_cnt_d;
  logic              cfg_err_q, cfg_err_d;
  logic              range_err_q, range_err_d;

  logic cfg_ok_s, accept_s, reject_s, hs_s;
  logic last_col_s, last_row_s, prime_last_s, out_of_range_s;

  assign cfg_ok_s = (cfg_rows >= DIM_W'(1)) && (cfg_rows <= DIM_W'(MAX_DIM)) &&
                    (cfg_cols >= DIM_W'(1)) && (cfg_cols <= DIM_W'(MAX_DIM)) &&
                    !($signed(cfg_min) > $signed(cfg_max));
  // abort outranks start even in IDLE, so neither accept nor reject fires with it
  assign accept_s       = (state_q == S_IDLE) && start && !abort && cfg_ok_s;
  assign reject_s       = (state_q == S_IDLE) && start && !abort && !cfg_ok_s;
  assign hs_s           = wr_valid && wr_ready;
  assign last_col_s     = (col_q == (cols_q - DIM_W'(1)));
  assign last_row_s     = (row_q == (rows_q - DIM_W'(1)));
  assign prime_last_s   = (prime_cnt_q == PCW'(PRIME_CYCLES - 1));
  assign out_of_range_s = ($signed(wr_data) < $signed(min_q)) ||
                          ($signed(wr_data) > $signed(max_q));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = accept_s ? S_SETTLE : S_IDLE;
        S_SETTLE: state_d = S_PRIME;
        S_PRIME:  state_d = prime_last_s ? S_FILL : S_PRIME;
        S_FILL:   state_d = (hs_s && last_row_s && last_col_s) ? S_DONE : S_FILL;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs; during FILL the RNG only advances when storage takes the element
  always_comb begin
    rng_en   = 1'b0;
    wr_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_SETTLE: rng_en = 1'b0;
      S_PRIME:  rng_en = 1'b1;
      S_FILL: begin
        wr_valid = 1'b1;
        rng_en   = wr_ready;
      end
      S_DONE:   done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // Datapath next-state: config latches, prime counter, index counters, error flags
  always_comb begin
    rows_d      = rows_q;
    cols_d      = cols_q;
    min_d       = min_q;
    max_d       = max_q;
    range_err_d = range_err_q;
    cfg_err_d   = reject_s;
    prime_cnt_d = {PCW{1'b0}};
    row_d       = row_q;
    col_d       = col_q;

    if (accept_s) begin
      rows_d      = cfg_rows;
      cols_d      = cfg_cols;
      min_d       = cfg_min;
      max_d       = cfg_max;
      range_err_d = 1'b0;
    end else if (hs_s && out_of_range_s) begin
      range_err_d = 1'b1;
    end else begin
      range_err_d = range_err_q;
    end

    if ((state_q == S_PRIME) && !abort) begin
      prime_cnt_d = prime_cnt_q + PCW'(1);
    end else begin
      prime_cnt_d = {PCW{1'b0}};
    end

    if (abort || (state_q != S_FILL)) begin
      row_d = {DIM_W{1'b0}};
      col_d = {DIM_W{1'b0}};
    end else if (hs_s) begin
      if (last_col_s) begin
        col_d = {DIM_W{1'b0}};
        row_d = last_row_s ? {DIM_W{1'b0}} : (row_q + DIM_W'(1));
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q      <= {DIM_W{1'b0}};
      cols_q      <= {DIM_W{1'b0}};
      min_q       <= {DATA_W{1'b0}};
      max_q       <= {DATA_W{1'b0}};
      row_q       <= {DIM_W{1'b0}};
      col_q       <= {DIM_W{1'b0}};
      prime_cnt_q <= {PCW{1'b0}};
      cfg_err_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      min_q       <= min_d;
      max_q       <= max_d;
      row_q       <= row_d;
      col_q       <= col_d;
      prime_cnt_q <= prime_cnt_d;
      cfg_err_q   <= cfg_err_d;
      range_err_q <= range_err_d;
    end
  end

  assign rng_min   = min_q;
  assign rng_max   = max_q;
  assign wr_data   = rng_val;
  assign wr_row    = row_q;
  assign wr_col    = col_q;
  assign cfg_err   = cfg_err_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_rand_matrix_filler.sv
// Directed bench for rand_matrix_filler with a 3-stage stub RNG and an index scoreboard.
module tb_rand_matrix_filler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       wr_ready = 1'b1;
  logic [2:0] cfg_rows = 3'd0, cfg_cols = 3'd0;
  logic [7:0] cfg_min = 8'd0, cfg_max = 8'd0;
  logic [7:0] rng_val, rng_min, rng_max, wr_data;
  logic [2:0] wr_row, wr_col;
  logic       rng_en, wr_valid, busy, done, cfg_err, range_err;

  rand_matrix_filler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .rng_en(rng_en), .rng_min(rng_min), .rng_max(rng_max), .rng_val(rng_val),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .busy(busy), .done(done), .cfg_err(cfg_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] r; logic [2:0] c; } idx_t;
  idx_t exp_q[$];

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int exp_min    = 0;
  int exp_max    = 0;
  logic force_hi = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Stub RNG: 3-stage pipeline that only shifts while rng_en is high
  logic [7:0] pipe0 = 8'd0, pipe1 = 8'd0, pipe2 = 8'd0;
  function automatic logic [7:0] gen_val();
    int lo, hi;
    lo = int'($signed(rng_min));
    hi = int'($signed(rng_max));
    if (force_hi) return 8'd100;
    if (hi < lo) return rng_min;
    return 8'(lo + int'($urandom_range(0, hi - lo)));
  endfunction
  always @(posedge clk) begin
    if (rng_en) begin
      pipe0 <= gen_val();
      pipe1 <= pipe0;
      pipe2 <= pipe1;
    end
  end
  assign rng_val = pipe2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes, index order, data range, stall stability
  int hs_cnt = 0, en_cnt = 0, last_hs_cyc = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [2:0] prev_row = 3'd0, prev_col = 3'd0;
  always @(negedge clk) begin
    idx_t e;
    if (rng_en) en_cnt <= en_cnt + 1;
    if (wr_valid) begin
      check("rng_en_follows_ready", rng_en, wr_ready);
      check("wr_data_passthru", wr_data, pipe2);
      if (!force_hi) begin
        check("data_ge_min", $signed(wr_data) >= exp_min, 1);
        check("data_le_max", $signed(wr_data) <= exp_max, 1);
      end
      if (prev_stall) begin
        check("stall_data", wr_data, prev_data);
        check("stall_row", wr_row, prev_row);
        check("stall_col", wr_col, prev_col);
      end
      if (wr_ready) begin
        hs_cnt      <= hs_cnt + 1;
        last_hs_cyc <= cyc;
        check("idx_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_row", wr_row, e.r);
          check("wr_col", wr_col, e.c);
        end
      end
    end
    prev_stall <= wr_valid && !wr_ready;
    prev_data  <= wr_data;
    prev_row   <= wr_row;
    prev_col   <= wr_col;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idx(input int r, input int c);
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        exp_q.push_back(idx_t'{r: 3'(i), c: 3'(j)});
  endtask

  task automatic pulse_start(input int r, input int c, input int mn, input int mx);
    cfg_rows = 3'(r);
    cfg_cols = 3'(c);
    cfg_min  = 8'(mn);
    cfg_max  = 8'(mx);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int bound, input int mode, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < bound; k++) begin
      wr_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      tick();
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    wr_ready = 1'b1;
    check("done_seen", done, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rng_en"}, rng_en, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_row"}, wr_row, 0);
    check({tag, "_col"}, wr_col, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, hs0, en0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_cfg_err", cfg_err, 0);
    check("rst_range_err", range_err, 0);
    check("rst_rng_min", rng_min, 0);
    check("rst_rng_max", rng_max, 0);
    rst_n = 1'b1;
    tick();

    // 2x3, [-5,10], ready tied high
    exp_min = -5; exp_max = 10;
    push_idx(2, 3);
    hs0 = hs_cnt; en0 = en_cnt;
    pulse_start(2, 3, -5, 10);
    check("settle_busy", busy, 1);
    check("settle_rng_en", rng_en, 0);
    check("settle_valid", wr_valid, 0);
    check("rng_min_latched", $signed(rng_min), -5);
    check("rng_max_latched", $signed(rng_max), 10);
    for (int p = 0; p < 3; p++) begin
      tick();
      check("prime_rng_en", rng_en, 1);
      check("prime_valid", wr_valid, 0);
    end
    tick();
    check("fill_valid", wr_valid, 1);
    wait_done(40, 0, dc);
    check("t1_hs_count", hs_cnt - hs0, 6);
    check("t1_done_after_last", dc, last_hs_cyc + 1);
    check("t1_rng_en_cycles", en_cnt - en0, 9);
    check("t1_range_err", range_err, 0);
    tick();
    check_idle("t1_post");
    check("t1_queue_empty", exp_q.size(), 0);

    // 1x1, min=max=7
    exp_min = 7; exp_max = 7;
    push_idx(1, 1);
    hs0 = hs_cnt; en0 = en_cnt;
    pulse_start(1, 1, 7, 7);
    wait_done(20, 0, dc);
    check("t2_hs_count", hs_cnt - hs0, 1);
    check("t2_rng_en_cycles", en_cnt - en0, 4);
    check("t2_done_after_last", dc, last_hs_cyc + 1);
    tick();

    // 3x3 with ready toggling 1,0,0
    exp_min = -20; exp_max = 20;
    push_idx(3, 3);
    hs0 = hs_cnt;
    pulse_start(3, 3, -20, 20);
    wait_done(200, 1, dc);
    check("t3_hs_count", hs_cnt - hs0, 9);
    check("t3_queue_empty", exp_q.size(), 0);
    tick();

    // Rejected starts leave the latches alone and never enable the RNG
    en0 = en_cnt;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       pulse_start(0, 3, 0, 5);
        1:       pulse_start(3, 6, 0, 5);
        default: pulse_start(2, 2, 20, -3);
      endcase
      check("rej_cfg_err", cfg_err, 1);
      check("rej_busy", busy, 0);
      tick();
      check("rej_cfg_err_pulse", cfg_err, 0);
      check("rej_busy_after", busy, 0);
      check("rej_rng_min_kept", $signed(rng_min), -20);
    end
    check("rej_no_rng_en", en_cnt - en0, 0);

    // start together with abort in IDLE
    abort = 1'b1;
    pulse_start(2, 2, 0, 5);
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_cfg_err", cfg_err, 0);
    tick();
    check("sa_busy_after", busy, 0);

    // Abort during the 4th element of a 5x5 fill
    exp_min = -128; exp_max = 127;
    push_idx(5, 5);
    hs0 = hs_cnt;
    pulse_start(5, 5, -128, 127);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (hs_cnt - hs0 == 3) break;
    end
    check("t5_reached_elem4", hs_cnt - hs0, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("t5_abort");
    check("t5_hs_incl_abort", hs_cnt - hs0, 4);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_no_done", done, 0);
    end
    push_idx(1, 2);
    hs0 = hs_cnt;
    pulse_start(1, 2, -128, 127);
    wait_done(30, 0, dc);
    check("t5_restart_hs", hs_cnt - hs0, 2);
    tick();

    // Out-of-range values from the RNG make range_err sticky
    force_hi = 1'b1;
    push_idx(2, 1);
    hs0 = hs_cnt;
    pulse_start(2, 1, 0, 50);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (hs_cnt - hs0 == 1) break;
    end
    check("t6_first_hs", hs_cnt - hs0, 1);
    check("t6_range_err_set", range_err, 1);
    wait_done(30, 0, dc);
    check("t6_range_err_at_done", range_err, 1);
    tick();
    check("t6_range_err_idle", range_err, 1);
    pulse_start(0, 1, 0, 50);
    check("t6_range_err_after_reject", range_err, 1);
    tick();
    force_hi = 1'b0;
    exp_min = 0; exp_max = 50;
    push_idx(1, 1);
    pulse_start(1, 1, 0, 50);
    check("t6_range_err_cleared", range_err, 0);
    wait_done(20, 0, dc);
    check("t6_range_err_clean_run", range_err, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
